// File: rtl/hex_word_assembler.sv
// rtl/hex_word_assembler.sv - ASCII hex digits to word assembler, CR-terminated; lowercase digits with HEX_LOWERCASE_EN
module hex_word_assembler #(
  parameter int NIBBLES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [4*NIBBLES-1:0] word_out,
  output logic                 word_valid,
  output logic                 err,
  output logic                 busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES + 1);

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DISCARD
  } state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    acc, acc_nxt, word_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            word_valid_nxt, err_nxt;
  logic            is_digit;
  logic [3:0]      nibble;

  // Digit decode: letters map via low nibble + 9 ('A' = 0x41 -> 10).
  always_comb begin
    is_digit = 1'b0;
    nibble   = 4'h0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      is_digit = 1'b1;
      nibble   = rx_data[3:0];
    end else if (rx_data >= 8'h41 && rx_data <= 8'h46) begin
      is_digit = 1'b1;
      nibble   = rx_data[3:0] + 4'd9;
    end
`ifdef HEX_LOWERCASE_EN
    else if (rx_data >= 8'h61 && rx_data <= 8'h66) begin
      is_digit = 1'b1;
      nibble   = rx_data[3:0] + 4'd9;
    end
`endif
  end

  always_comb begin
    state_nxt      = state;
    acc_nxt        = acc;
    cnt_nxt        = cnt;
    word_nxt       = word_out;
    word_valid_nxt = 1'b0;
    err_nxt        = 1'b0;
    if (rx_valid && rx_data != CHAR_LF) begin
      unique case (state)
        IDLE: begin
          if (is_digit) begin
            acc_nxt   = W'(nibble);
            cnt_nxt   = CW'(1);
            state_nxt = ACCUM;
          end else if (rx_data != CHAR_CR) begin
            err_nxt   = 1'b1;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = DISCARD;
          end
        end
        ACCUM: begin
          if (is_digit && cnt != CW'(NIBBLES)) begin
            acc_nxt = (acc << 4) | W'(nibble);
            cnt_nxt = cnt + CW'(1);
          end else if (rx_data == CHAR_CR) begin
            word_nxt       = acc;
            word_valid_nxt = 1'b1;
            acc_nxt        = '0;
            cnt_nxt        = '0;
            state_nxt      = IDLE;
          end else begin
            // Overflow digit or bad character both abandon the line.
            err_nxt   = 1'b1;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = DISCARD;
          end
        end
        DISCARD: begin
          if (rx_data == CHAR_CR) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      cnt        <= cnt_nxt;
      word_out   <= word_nxt;
      word_valid <= word_valid_nxt;
      err        <= err_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_hex_word_assembler.sv
// tb/tb_hex_word_assembler.sv - randomized bench for hex_word_assembler against a line-level model
module tb_hex_word_assembler;

  localparam int NIBBLES = 8;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic [W-1:0] word_out;
  logic         word_valid;
  logic         err;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  // Line-level model state: digits seen on the current line, and whether the line already failed.
  int           line_digits[$];
  bit           line_bad = 1'b0;
  logic [W-1:0] exp_word = '0;
  bit           exp_wv = 1'b0;
  bit           exp_err = 1'b0;
  bit           exp_busy = 1'b0;

  hex_word_assembler #(.NIBBLES(NIBBLES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .word_out   (word_out),
    .word_valid (word_valid),
    .err        (err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int hex_value(input logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "A" && b <= "F") return int'(b) - 55;
`ifdef HEX_LOWERCASE_EN
    if (b >= "a" && b <= "f") return int'(b) - 87;
`endif
    return -1;
  endfunction

  function automatic void model_step(input bit v, input logic [7:0] b);
    longint val;
    exp_wv  = 1'b0;
    exp_err = 1'b0;
    if (v && b != 8'h0A) begin
      if (b == 8'h0D) begin
        if (!line_bad && line_digits.size() > 0) begin
          val = 0;
          foreach (line_digits[i]) val = val * 16 + line_digits[i];
          exp_word = W'(val);
          exp_wv   = 1'b1;
        end
        line_digits.delete();
        line_bad = 1'b0;
      end else if (!line_bad) begin
        if (hex_value(b) >= 0 && line_digits.size() < NIBBLES) begin
          line_digits.push_back(hex_value(b));
        end else begin
          exp_err  = 1'b1;
          line_bad = 1'b1;
          line_digits.delete();
        end
      end
    end
    exp_busy = line_bad || (line_digits.size() > 0);
  endfunction

  task automatic check_outputs();
    check("word_out",   word_out,          exp_word);
    check("word_valid", W'(word_valid),    W'(exp_wv));
    check("err",        W'(err),           W'(exp_err));
    check("busy",       W'(busy),          W'(exp_busy));
  endtask

  // Check the result of the previous edge, then present the next input.
  task automatic cycle(input bit v, input logic [7:0] b);
    @(negedge clk);
    check_outputs();
    rx_valid = v;
    rx_data  = b;
    model_step(v, b);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) cycle(1'b1, s[i]);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    check_outputs();
    rx_valid = 1'b0;
    rst_n    = 1'b0;
    line_digits.delete();
    line_bad = 1'b0;
    exp_word = '0;
    exp_wv   = 1'b0;
    exp_err  = 1'b0;
    exp_busy = 1'b0;
    #1;
    check_outputs();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] random_byte();
    logic [7:0] hexchars [16];
    int sel;
    for (int i = 0; i < 10; i++) hexchars[i] = 8'(48 + i);
    for (int i = 0; i < 6; i++) hexchars[10 + i] = 8'(65 + i);
    sel = $urandom_range(0, 99);
    if (sel < 60) return hexchars[$urandom_range(0, 15)];
    if (sel < 75) return 8'h0D;
    if (sel < 82) return 8'h0A;
    if (sel < 90) return 8'(97 + $urandom_range(0, 5));
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    @(negedge clk);
    check_outputs();
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    send_str("1A2B\r");
    cycle(1'b0, 8'h00);
    check("1A2B", word_out, 32'h00001A2B);
    send_str("DEADBEEF\r");
    send_str("DEADBEEF0\r");
    send_str("12G4\r5\r");
    cycle(1'b0, 8'h00);
    check("G line then 5", word_out, 32'h5);
    send_str("\r\n\r");
    send_str("7\n7\r");
    cycle(1'b0, 8'h00);
    check("7 LF 7", word_out, 32'h77);
    send_str("ab\r");
    send_str("12");
    apply_reset();
    send_str("3\r");
    cycle(1'b0, 8'h00);
    check("after reset", word_out, 32'h3);
    send_str("FFFFFFFF\rZ\r00000001\r");

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) cycle(1'b0, 8'($urandom_range(0, 255)));
      else cycle(1'b1, random_byte());
      if ($urandom_range(0, 499) == 0) apply_reset();
    end

    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hex_word_assembler.md
HEX_WORD_ASSEMBLER -- requirements
Module: hex_word_assembler

Interface
REQ-001 Parameter: NIBBLES, 8, number of hex digits per word (1..8); word width W = 4*NIBBLES.
REQ-002 Port: clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: rx_data  input  8  ASCII byte from the UART receiver.
REQ-005 Port: rx_valid  input  1  one-cycle strobe; rx_data is valid in the same cycle.
REQ-006 Port: word_out  output  W  assembled word; holds its value until the next accepted word.
REQ-007 Port: word_valid  output  1  one-cycle pulse when word_out is updated.
REQ-008 Port: err  output  1  one-cycle pulse on a framing, character or overflow error.
REQ-009 Port: busy  output  1  high when not in IDLE.

Function
REQ-010 The FSM SHALL have three states: IDLE, ACCUM and DISCARD; the internal accumulator acc is W bits and the digit counter cnt counts 0..NIBBLES.
REQ-011 A byte SHALL be processed only in a cycle where rx_valid=1; with rx_valid=0 all state holds.
REQ-012 Hex digit classes: 0x30-0x39 map to 0-9, and 0x41-0x46 map to A-F; all other bytes are non-digits except CR (0x0D) and LF (0x0A).
REQ-013 In IDLE, a digit SHALL load acc={0,nibble}, set cnt=1 and go to ACCUM.
REQ-014 In ACCUM, a digit with cnt<NIBBLES SHALL shift acc left 4 bits, insert the nibble in bits [3:0] and increment cnt.
REQ-015 In ACCUM, a digit with cnt==NIBBLES SHALL be an overflow: pulse err, clear acc and cnt, and go to DISCARD.
REQ-016 In ACCUM, a CR SHALL register word_out=acc (right-justified, zero-extended), pulse word_valid, clear acc and cnt, and go to IDLE.
REQ-017 word_valid and err SHALL assert in the cycle after the triggering rx_valid; latency is 1 clock.
REQ-018 LF SHALL be ignored in every state.
REQ-019 A CR in IDLE SHALL be ignored, with no pulse.
REQ-020 Any other non-digit in IDLE or ACCUM SHALL pulse err, clear acc and cnt, and go to DISCARD.
REQ-021 In DISCARD, all bytes except CR SHALL be dropped with no further err pulse; a CR SHALL return the FSM to IDLE without word_valid.
REQ-022 word_valid and err SHALL never assert in the same cycle.
REQ-023 Back-to-back rx_valid on consecutive cycles SHALL be accepted without loss.

Reset
REQ-024 While rst_n=0, the block SHALL force state=IDLE, acc=0, cnt=0, word_out=0, word_valid=0, err=0 and busy=0, asynchronously.
REQ-025 Reset asserted mid-word SHALL discard the partial word, with no pulse after release.
REQ-026 Reset release SHALL be synchronous to clk; the first byte is accepted on the first edge after release.

Configuration
REQ-027 With macro HEX_LOWERCASE_EN defined, bytes 0x61-0x66 SHALL also be digits (a-f map to A-F).
REQ-028 Without HEX_LOWERCASE_EN, bytes 0x61-0x66 SHALL be non-digits per REQ-020.

Verification
REQ-029 Send "1A2B" then CR with NIBBLES=8 -> word_valid pulses 1 cycle after CR, word_out=0x00001A2B.
REQ-030 Send "DEADBEEF" then CR -> word_out=0xDEADBEEF; sending a 9th digit '0' before CR instead -> err pulse, DISCARD, and CR gives no word_valid.
REQ-031 Send "12G4" then CR "5" CR -> err once on 'G', no word for the first line, then word_out=0x5.
REQ-032 Send CR, LF, CR in IDLE -> no pulses and busy stays 0; send "7" LF "7" CR -> word_out=0x77.
REQ-033 Send "ab" then CR -> 0xAB with HEX_LOWERCASE_EN defined; without it -> err and no word.
REQ-034 Pulse rst_n low after "12" -> all outputs 0; then "3" CR -> word_out=0x3.
